movegen_scheduler: RTL and testbench

MOVEGEN_SCHEDULER -- requirements
Module: movegen_scheduler

---
 rtl/movegen_pkg.sv | 24 ++
 rtl/movegen_pick.sv | 12 +
 rtl/movegen_scheduler.sv | 109 ++++++++++
 tb/tb_movegen_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/movegen_pkg.sv
// movegen_pkg: shared FSM states, direction indices and hit_vec bit mapping for the move-generation scheduler
package movegen_pkg;
  localparam int HIT_W = 16;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_FETCH, S_EMIT, S_DONE} state_t;
  localparam logic [3:0] DIR_U   = 4'd0;
  localparam logic [3:0] DIR_D   = 4'd1;
  localparam logic [3:0] DIR_L   = 4'd2;
  localparam logic [3:0] DIR_R   = 4'd3;
  localparam logic [3:0] DIR_UL  = 4'd4;
  localparam logic [3:0] DIR_UR  = 4'd5;
  localparam logic [3:0] DIR_DL  = 4'd6;
  localparam logic [3:0] DIR_DR  = 4'd7;
  localparam logic [3:0] DIR_UUL = 4'd8;
  localparam logic [3:0] DIR_UUR = 4'd9;
  localparam logic [3:0] DIR_LLU = 4'd10;
  localparam logic [3:0] DIR_RRU = 4'd11;
  localparam logic [3:0] DIR_DDL = 4'd12;
  localparam logic [3:0] DIR_DDR = 4'd13;
  localparam logic [3:0] DIR_LLD = 4'd14;
  localparam logic [3:0] DIR_RRD = 4'd15;
  function automatic logic [HIT_W-1:0] dir_bit(input logic [3:0] d);
    return HIT_W'(1) << d;
  endfunction
endpackage

// File: rtl/movegen_pick.sv
// movegen_pick: combinational lowest-set-bit encoder, 16-bit pending mask to 4-bit direction index
module movegen_pick
  import movegen_pkg::*;
(
  input  logic [HIT_W-1:0] i_mask,
  output logic [3:0]       o_idx
);
  always_comb begin
    o_idx = '0;
    for (int i = HIT_W - 1; i >= 0; i--) o_idx = i_mask[i] ? 4'(i) : o_idx;
  end
endmodule

// File: rtl/movegen_scheduler.sv
// movegen_scheduler: sequences load/settle of the cell array, then scans every square and streams one move record per set hit bit
// Optional MOVEGEN_ABORT_EN adds an abort input that drops the pass back to IDLE without a done pulse.
module movegen_scheduler
  import movegen_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int NUM_SQ        = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef MOVEGEN_ABORT_EN
  input  logic             abort,
`endif
  input  logic             engine_color,
  output logic             color_q,
  output logic             load_en,
  output logic             prop_en,
  output logic [5:0]       sq_sel,
  input  logic [HIT_W-1:0] hit_vec,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [5:0]       mv_from,
  output logic [3:0]       mv_dir,
  output logic             busy,
  output logic             done,
  output logic [10:0]      mv_count
);
  localparam int SC = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  state_t            r_state, w_next;
  logic [31:0]       r_settle;
  logic [HIT_W-1:0]  r_pending;
  logic [5:0]        r_sq_sel;
  logic [10:0]       r_count;
  logic              r_color;
  logic [3:0]        w_dir;
  logic [HIT_W-1:0]  w_left;
  logic              w_abort, w_adv, w_accept, w_last;
`ifdef MOVEGEN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif
  movegen_pick u_pick (.i_mask(r_pending), .o_idx(w_dir));
  assign w_left = r_pending & ~dir_bit(w_dir);
  assign w_last = r_sq_sel == 6'(NUM_SQ - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next   = r_state;
    w_adv    = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE:   w_next = start ? S_LOAD : S_IDLE;
      S_LOAD:   w_next = S_SETTLE;
      S_SETTLE: w_next = (r_settle == 32'(SC - 1)) ? S_FETCH : S_SETTLE;
      S_FETCH:  begin
        w_next = (hit_vec != '0) ? S_EMIT : S_FETCH;
        w_adv  = hit_vec == '0;
      end
      S_EMIT:   begin
        w_accept = mv_ready;
        w_adv    = mv_ready && w_left == '0;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_adv) w_next = w_last ? S_DONE : S_FETCH;
    if (w_abort && r_state != S_IDLE) begin
      w_next   = S_IDLE;
      w_adv    = 1'b0;
      w_accept = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle  <= '0;
      r_pending <= '0;
      r_sq_sel  <= '0;
      r_count   <= '0;
      r_color   <= 1'b0;
    end else begin
      r_settle <= (r_state == S_SETTLE) ? r_settle + 32'd1 : '0;
      if (r_state == S_IDLE && start) begin
        r_color   <= engine_color;
        r_count   <= '0;
        r_sq_sel  <= '0;
        r_pending <= '0;
      end
      if (r_state == S_FETCH) r_pending <= hit_vec;
      if (w_accept) begin
        r_pending <= w_left;
        r_count   <= (r_count == '1) ? r_count : r_count + 11'd1;
      end
      if (w_adv && !w_last) r_sq_sel <= r_sq_sel + 6'd1;
    end
  end
  assign color_q  = r_color;
  assign load_en  = r_state == S_LOAD;
  assign prop_en  = r_state == S_SETTLE;
  assign mv_valid = r_state == S_EMIT;
  assign busy     = r_state != S_IDLE;
  assign done     = r_state == S_DONE;
  assign sq_sel   = r_sq_sel;
  assign mv_from  = r_sq_sel;
  assign mv_dir   = w_dir;
  assign mv_count = r_count;
endmodule

// File: tb/tb_movegen_scheduler.sv
// tb_movegen_scheduler: directed checks of the move-generation scheduler against hand-computed expectations
module tb_movegen_scheduler;
  logic        clk = 1'b0;
  logic        rst_n, start, engine_color, mv_ready;
  logic        color_q, load_en, prop_en, mv_valid, busy, done;
  logic [5:0]  sq_sel, mv_from;
  logic [3:0]  mv_dir;
  logic [10:0] mv_count;
  logic [15:0] hit_vec;
  logic [15:0] hits [64];
`ifdef MOVEGEN_ABORT_EN
  logic        abort = 1'b0;
`endif
  int n_checks = 0, n_errors = 0;
  int n_load, n_prop, n_fetch, n_done;
  logic [9:0] recs [$];
  int rec_cyc [$];

  always #5 clk = ~clk;
  assign hit_vec = hits[sq_sel];

  movegen_scheduler #(.SETTLE_CYCLES(8), .NUM_SQ(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef MOVEGEN_ABORT_EN
    .abort(abort),
`endif
    .engine_color(engine_color), .color_q(color_q), .load_en(load_en), .prop_en(prop_en),
    .sq_sel(sq_sel), .hit_vec(hit_vec), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_from(mv_from), .mv_dir(mv_dir), .busy(busy), .done(done), .mv_count(mv_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_hits();
    for (int i = 0; i < 64; i++) hits[i] = 16'h0;
  endtask

  // Called at a falling edge; runs one pass and records activity until 10 cycles past done.
  task automatic run_pass(input bit inj_start, input int budget);
    int tail;
    n_load = 0; n_prop = 0; n_fetch = 0; n_done = 0; tail = -1;
    recs.delete(); rec_cyc.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < budget && tail != 0; c++) begin
      if (load_en) n_load++;
      if (prop_en) n_prop++;
      if (busy && !load_en && !prop_en && !mv_valid && !done) n_fetch++;
      if (mv_valid && mv_ready) begin
        recs.push_back({mv_from, mv_dir});
        rec_cyc.push_back(c);
      end
      if (done) begin
        n_done++;
        if (tail < 0) tail = 10;
      end
      start = inj_start && prop_en && n_prop == 3;
      @(negedge clk);
      if (tail > 0) tail--;
    end
    start = 1'b0;
  endtask

  initial begin
    int stable, bad;
    logic [9:0] e;
    rst_n = 1'b0; start = 1'b0; engine_color = 1'b0; mv_ready = 1'b0;
    clear_hits();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_load", load_en, 0);
    chk("rst_prop", prop_en, 0);
    chk("rst_valid", mv_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_sq", sq_sel, 0);
    chk("rst_count", mv_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    engine_color = 1'b1; mv_ready = 1'b1;
    run_pass(1'b0, 200);
    chk("empty_load", n_load, 1);
    chk("empty_prop", n_prop, 8);
    chk("empty_fetch", n_fetch, 64);
    chk("empty_done", n_done, 1);
    chk("empty_count", mv_count, 0);
    chk("empty_color", color_q, 1);

    engine_color = 1'b0;
    hits[12] = 16'h0101;
    run_pass(1'b0, 200);
    chk("sq12_nrec", recs.size(), 2);
    if (recs.size() == 2) begin
      chk("sq12_rec0", recs[0], {6'd12, 4'd0});
      chk("sq12_rec1", recs[1], {6'd12, 4'd8});
      chk("sq12_consec", rec_cyc[1] - rec_cyc[0], 1);
    end
    chk("sq12_count", mv_count, 2);
    chk("sq12_done", n_done, 1);
    chk("sq12_color", color_q, 0);

    clear_hits();
    hits[5] = 16'h0020;
    mv_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && !mv_valid; c++) @(negedge clk);
    chk("hold_reach", mv_valid, 1);
    stable = 0;
    for (int k = 0; k < 10; k++) begin
      if (mv_valid && mv_from == 6'd5 && mv_dir == 4'd5) stable++;
      @(negedge clk);
    end
    chk("hold_stable", stable, 10);
    chk("hold_valid11", mv_valid, 1);
    chk("hold_count0", mv_count, 0);
    mv_ready = 1'b1;
    @(negedge clk);
    chk("hold_accepted", mv_valid, 0);
    chk("hold_count1", mv_count, 1);
    bad = 1;
    for (int c = 0; c < 200 && bad != 0; c++) begin
      if (done) bad = 0;
      @(negedge clk);
    end
    chk("hold_done_seen", bad, 0);

    for (int i = 0; i < 64; i++) hits[i] = 16'hFFFF;
    run_pass(1'b0, 2000);
    chk("full_nrec", recs.size(), 1024);
    chk("full_count", mv_count, 1024);
    bad = 0;
    for (int i = 0; i < recs.size() && i < 1024; i++) begin
      e = {6'(i / 16), 4'(i % 16)};
      if (recs[i] !== e) bad++;
    end
    chk("full_order", bad, 0);
    chk("full_done", n_done, 1);

    clear_hits();
    run_pass(1'b1, 200);
    chk("dup_start_done", n_done, 1);
    chk("dup_start_prop", n_prop, 8);
    chk("dup_start_idle", busy, 0);

    hits[5] = 16'h0002;
    mv_ready = 1'b0; engine_color = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && !mv_valid; c++) @(negedge clk);
    chk("rstmid_reach", mv_valid, 1);
    chk("rstmid_color", color_q, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", mv_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_color0", color_q, 0);
    chk("rstmid_sq", sq_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) bad++;
      @(negedge clk);
    end
    chk("rstmid_nodone", bad, 0);

`ifdef MOVEGEN_ABORT_EN
    hits[5] = 16'h0003;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && !mv_valid; c++) @(negedge clk);
    chk("abort_reach", mv_valid, 1);
    mv_ready = 1'b1;
    @(negedge clk);
    mv_ready = 1'b0;
    chk("abort_pre_count", mv_count, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", mv_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", mv_count, 1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) bad++;
      @(negedge clk);
    end
    chk("abort_nodone", bad, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
